// File: rtl/instruction_fetch_queue.sv
// ============================================================================
// Module   : instruction_fetch_queue
// Purpose  : Fetch-group request generator feeding a circular instruction queue
//            with multi-slot head presentation and redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_queue #(
   parameter int          FETCH_WIDTH     = 8,
   parameter int          DEPTH           = 16,
   parameter logic [31:0] START_BYTE_ADDR = 32'h0000_3000
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   output logic [31:0]                          imem_addr,
   input  logic [FETCH_WIDTH-1:0][31:0]         imem_data,
   input  logic                                 redirect_valid,
   input  logic [31:0]                          redirect_pc,
   input  logic [$clog2(FETCH_WIDTH+1)-1:0]     deq_count,
   output logic [FETCH_WIDTH-1:0][31:0]         out_instr,
   output logic [FETCH_WIDTH-1:0][31:0]         out_pc,
   output logic [$clog2(FETCH_WIDTH+1)-1:0]     out_valid_count,
   output logic                                 full,
   output logic                                 empty
);

   localparam int c_cw = $clog2(FETCH_WIDTH + 1);
   localparam int c_pw = $clog2(DEPTH);
   localparam int c_nw = $clog2(DEPTH + 1);

   localparam logic [c_nw-1:0] c_depth_n   = c_nw'(DEPTH);
   localparam logic [c_nw-1:0] c_fw_n      = c_nw'(FETCH_WIDTH);
   localparam logic [c_cw-1:0] c_fw_c      = c_cw'(FETCH_WIDTH);
   localparam logic [c_pw-1:0] c_fw_p      = c_pw'(FETCH_WIDTH);
   localparam logic [31:0]     c_grp_bytes = 32'(4 * FETCH_WIDTH);

   logic [31:0]     mem_instr_q [DEPTH];
   logic [31:0]     mem_pc_q    [DEPTH];

   logic [c_pw-1:0] head_q, head_d;
   logic [c_pw-1:0] tail_q, tail_d;
   logic [c_nw-1:0] count_q, count_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic            inflight_q, inflight_d;
   logic [31:0]     inflight_pc_q, inflight_pc_d;

   logic            w_req_fire;
   logic            w_write;
   logic [c_cw-1:0] w_eff_deq;
   logic [31:0]     w_credit;

   assign imem_addr       = fetch_pc_q;
   assign full            = (count_q == c_depth_n);
   assign empty           = (count_q == '0);
   assign out_valid_count = (count_q >= c_fw_n) ? c_fw_c : c_cw'(count_q);

   // Space is reserved for the outstanding group too, so the queue can never overflow.
   assign w_credit   = 32'(count_q) + (inflight_q ? 32'(FETCH_WIDTH) : 32'd0) + 32'(FETCH_WIDTH);
   assign w_req_fire = !redirect_valid && (w_credit <= 32'(DEPTH));
   assign w_write    = inflight_q && !redirect_valid;
   assign w_eff_deq  = (deq_count < out_valid_count) ? deq_count : out_valid_count;

   always_comb begin
      head_d        = head_q + c_pw'(w_eff_deq);
      tail_d        = w_write ? (tail_q + c_fw_p) : tail_q;
      count_d       = count_q - c_nw'(w_eff_deq) + (w_write ? c_fw_n : '0);
      inflight_d    = w_req_fire;
      inflight_pc_d = w_req_fire ? fetch_pc_q : inflight_pc_q;
      fetch_pc_d    = w_req_fire ? (fetch_pc_q + c_grp_bytes) : fetch_pc_q;
      if (redirect_valid) begin
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         inflight_d = 1'b0;
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         fetch_pc_q    <= START_BYTE_ADDR;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   // Storage needs no reset: slots beyond out_valid_count are forced to zero.
   always_ff @(posedge clk) begin
      if (w_write) begin
         for (int k = 0; k < FETCH_WIDTH; k++) begin
            mem_instr_q[tail_q + c_pw'(k)] <= imem_data[k];
            mem_pc_q[tail_q + c_pw'(k)]    <= inflight_pc_q + 32'(4 * k);
         end
      end
   end

   for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
      logic [c_pw-1:0] w_idx;
      logic            w_vld;
      assign w_idx        = head_q + c_pw'(k);
      assign w_vld        = (c_cw'(k) < out_valid_count);
      assign out_instr[k] = w_vld ? mem_instr_q[w_idx] : 32'd0;
      assign out_pc[k]    = w_vld ? mem_pc_q[w_idx] : 32'd0;
   end

endmodule

`default_nettype wire
